clk_div_bank: RTL and testbench

- Multi-channel programmable clock divider. It produces NUM_CH independent divided-clock outputs and single-cycle tick strobes from one system clock.
- Each channel's divisor is programmable at run time through a simple write port. New values take effect glitch-free at that channel's next terminal count.
- A global sync pulse phase-aligns all channels.
- Feeds LED blinkers, sampling strobes and slow peripheral timing in the DE0-Nano test designs.

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_chan.sv | 50 +++++
 rtl/clk_div_bank.sv | 50 +++++
 tb/tb_clk_div_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider bank.
// calc_div returns the terminal-count value that gives a 50% div_clk at f_out.
package clk_div_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int unsigned DEFAULT_DIV_1HZ_100M = 49_999_999;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // div_clk period is 2*(div+1) input cycles; a zero f_out saturates to the slowest rate
  function automatic cnt_t calc_div(input longint unsigned f_in,
                                    input longint unsigned f_out);
    longint unsigned q;
    if (f_out == 0) return '1;
    q = f_in / (2 * f_out);
    return (q == 0) ? '0 : cnt_t'(q - 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free counter, shadow/active divisor pair, tick strobe
// and toggling div_clk. Divisor changes land only at terminal count or sync.
module clk_div_chan import clk_div_pkg::*; #(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_1HZ_100M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  output logic             div_clk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt, active_div, shadow_div, next_div;
  logic             tc;

  assign tc       = en && (cnt == active_div);
  // A write coinciding with TC or sync feeds the next period directly
  assign next_div = wr ? wdata : shadow_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      active_div <= DEFAULT_DIV;
      shadow_div <= DEFAULT_DIV;
      div_clk    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (wr) shadow_div <= wdata;
      if (sync) begin
        cnt        <= '0;
        div_clk    <= 1'b0;
        tick       <= 1'b0;
        active_div <= next_div;
      end else if (tc) begin
        cnt        <= '0;
        tick       <= 1'b1;
        div_clk    <= ~div_clk;
        active_div <= next_div;
      end else begin
        tick <= 1'b0;
        if (en) cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// NUM_CH independent programmable dividers sharing one config write port
// and a global phase-align sync.
module clk_div_bank import clk_div_pkg::*; #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_1HZ_100M),
  localparam int              CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] wr_ch;
  logic              bad_ch;

  // One extra bit so NUM_CH itself is representable when it is a power of two
  assign bad_ch = ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_wr && bad_ch;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ch[i] = cfg_wr && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr_ch[i]),
      .wdata   (cfg_div),
      .div_clk (div_clk[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with NUM_CH=3 so the invalid-channel path is reachable.
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 32;
  localparam int CH_W   = $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              sync = 1'b0;
  logic              cfg_wr = 1'b0;
  logic              cfg_err;
  logic [NUM_CH-1:0] en = '0;
  logic [NUM_CH-1:0] div_clk, tick;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_err (cfg_err),
    .div_clk (div_clk),
    .tick    (tick)
  );

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int unsigned d);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d);
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*NUM_CH:0] exp_v;
    exp_v = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if ({cfg_err, div_clk, tick} !== exp_v)
      $display("FAIL reset_state: got %b want %b", {cfg_err, div_clk, tick}, exp_v);
    else passed++;
    cyc(2);
    rst_n = 1'b1;
    en = '1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      checks++;
      if ({div_clk, tick} !== '0)
        $display("FAIL default_div_quiet k=%0d: got %b want 0", k, {div_clk, tick});
      else passed++;
    end
  endtask

  task automatic test_div3();
    logic et, ec;
    wr(0, 3);
    do_sync();
    checks++;
    if ({tick[0], div_clk[0]} !== 2'b00)
      $display("FAIL div3_after_sync: got %b want 00", {tick[0], div_clk[0]});
    else passed++;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      et = (k % 4 == 0);
      ec = ((k / 4) % 2 == 1);
      checks++;
      if ({tick[0], div_clk[0]} !== {et, ec})
        $display("FAIL div3 k=%0d: got tick,clk=%b want %b", k, {tick[0], div_clk[0]}, {et, ec});
      else passed++;
    end
  endtask

  task automatic test_mid_write();
    logic et, ec;
    wr(1, 9);
    do_sync();
    for (int k = 1; k <= 19; k++) begin
      if (k == 6) begin cfg_wr = 1'b1; cfg_ch = CH_W'(1); cfg_div = CNT_W'(2); end
      cyc();
      cfg_wr = 1'b0;
      et = (k >= 10) && ((k - 10) % 3 == 0);
      ec = (k >= 10) && (((k - 10) / 3) % 2 == 0);
      checks++;
      if ({tick[1], div_clk[1]} !== {et, ec})
        $display("FAIL mid_write k=%0d: got tick,clk=%b want %b", k, {tick[1], div_clk[1]}, {et, ec});
      else passed++;
    end
  endtask

  task automatic test_div0();
    cfg_wr = 1'b1; cfg_ch = CH_W'(2); cfg_div = '0; sync = 1'b1;
    cyc();
    cfg_wr = 1'b0; sync = 1'b0;
    checks++;
    if ({tick[2], div_clk[2]} !== 2'b00)
      $display("FAIL div0_after_sync: got %b want 00", {tick[2], div_clk[2]});
    else passed++;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++;
      if ({tick[2], div_clk[2]} !== {1'b1, (k % 2 == 1)})
        $display("FAIL div0 k=%0d: got tick,clk=%b want %b", k, {tick[2], div_clk[2]}, {1'b1, (k % 2 == 1)});
      else passed++;
    end
  endtask

  task automatic test_en_freeze();
    wr(0, 4);
    do_sync();
    cyc(2);
    en[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      checks++;
      if ({tick[0], div_clk[0]} !== 2'b00)
        $display("FAIL en_freeze k=%0d: got tick,clk=%b want 00", k, {tick[0], div_clk[0]});
      else passed++;
    end
    en[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++;
      if ({tick[0], div_clk[0]} !== {(k == 3), (k == 3)})
        $display("FAIL en_resume k=%0d: got tick,clk=%b want %b", k, {tick[0], div_clk[0]}, {(k == 3), (k == 3)});
      else passed++;
    end
  endtask

  task automatic test_sync_align();
    logic [NUM_CH-1:0] et, ec;
    wr(0, 3); wr(1, 5); wr(2, 7);
    do_sync();
    cyc(5);
    checks++;
    if (div_clk[0] !== 1'b1)
      $display("FAIL pre_sync_phase: got div_clk0=%b want 1", div_clk[0]);
    else passed++;
    do_sync();
    checks++;
    if ({div_clk, tick} !== '0)
      $display("FAIL sync_clear: got %b want 0", {div_clk, tick});
    else passed++;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      et = {(k == 8), (k == 6), (k % 4 == 0)};
      ec = {(k >= 8), (k >= 6), (k >= 4 && k < 8)};
      checks++;
      if ({tick, div_clk} !== {et, ec})
        $display("FAIL sync_align k=%0d: got tick=%b clk=%b want tick=%b clk=%b", k, tick, div_clk, et, ec);
      else passed++;
    end
  endtask

  task automatic test_bypass();
    logic ec;
    do_sync();
    cyc(3);
    cfg_wr = 1'b1; cfg_ch = '0; cfg_div = CNT_W'(1);
    cyc();
    cfg_wr = 1'b0;
    checks++;
    if ({tick[0], div_clk[0]} !== 2'b11)
      $display("FAIL bypass_tc: got tick,clk=%b want 11", {tick[0], div_clk[0]});
    else passed++;
    for (int k = 5; k <= 8; k++) begin
      cyc();
      ec = (((k - 4) / 2) % 2 == 0);
      checks++;
      if ({tick[0], div_clk[0]} !== {(k % 2 == 0), ec})
        $display("FAIL bypass k=%0d: got tick,clk=%b want %b", k, {tick[0], div_clk[0]}, {(k % 2 == 0), ec});
      else passed++;
    end
  endtask

  task automatic test_cfg_err();
    logic [NUM_CH-1:0] et;
    checks++;
    if (cfg_err !== 1'b0) $display("FAIL cfg_err_idle: got %b want 0", cfg_err);
    else passed++;
    cfg_wr = 1'b1; cfg_ch = CH_W'(3); cfg_div = '0;
    cyc();
    cfg_wr = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) $display("FAIL cfg_err_set: got %b want 1", cfg_err);
    else passed++;
    cyc();
    checks++;
    if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear: got %b want 0", cfg_err);
    else passed++;
    do_sync();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      et = {(k == 8), (k == 6), (k % 2 == 0)};
      checks++;
      if (tick !== et)
        $display("FAIL bad_ch_no_effect k=%0d: got tick=%b want %b", k, tick, et);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    cfg_wr = 1'b1; cfg_ch = CH_W'(2); cfg_div = '0; sync = 1'b1;
    cyc();
    sync = 1'b0; cfg_ch = CH_W'(3);
    cyc();
    cfg_wr = 1'b0;
    checks++;
    if ({tick[2], cfg_err} !== 2'b11)
      $display("FAIL pre_reset_active: got tick2,err=%b want 11", {tick[2], cfg_err});
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_err, div_clk, tick} !== '0)
      $display("FAIL async_reset: got %b want 0", {cfg_err, div_clk, tick});
    else passed++;
    cyc(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      checks++;
      if ({div_clk, tick} !== '0)
        $display("FAIL post_reset_default k=%0d: got %b want 0", k, {div_clk, tick});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_div3();
    test_mid_write();
    test_div0();
    test_en_freeze();
    test_sync_align();
    test_bypass();
    test_cfg_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
